// File: rtl/vga_window_scanner.sv
// Parametrised VGA timing generator that scans a (optionally upscaled) image window,
// reads a synchronous pixel memory and realigns the grayscale data with sync/DE.
module vga_window_scanner #(
    parameter int       H_ACTIVE   = 640,
    parameter int       H_FP       = 16,
    parameter int       H_SYNC     = 96,
    parameter int       H_BP       = 48,
    parameter int       V_ACTIVE   = 480,
    parameter int       V_FP       = 10,
    parameter int       V_SYNC     = 2,
    parameter int       V_BP       = 33,
    parameter int       WIN_X      = 170,
    parameter int       WIN_Y      = 90,
    parameter int       IMG_W      = 300,
    parameter int       IMG_H      = 300,
    parameter int       SCALE_LOG2 = 0,
    parameter int       ADDR_W     = 18,
    parameter int       MEM_LAT    = 2,
    parameter bit [7:0] BG_GRAY    = 8'h00,
    parameter bit       BORDER_EN  = 1'b1,
    parameter bit       SYNC_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start,
    output logic              busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL + 1);
    localparam int VCW     = $clog2(V_TOTAL + 1);
    localparam int WW      = IMG_W << SCALE_LOG2;
    localparam int WH      = IMG_H << SCALE_LOG2;
    localparam int LAT     = MEM_LAT + 1;
    localparam int BX0     = (WIN_X > 0) ? WIN_X - 1 : 0;
    localparam int BY0     = (WIN_Y > 0) ? WIN_Y - 1 : 0;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
    localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HCW-1:0] WX_BEG   = HCW'(WIN_X);
    localparam logic [HCW-1:0] WX_END   = HCW'(WIN_X + WW);
    localparam logic [VCW-1:0] WY_BEG   = VCW'(WIN_Y);
    localparam logic [VCW-1:0] WY_END   = VCW'(WIN_Y + WH);
    localparam logic [HCW-1:0] BX_BEG   = HCW'(BX0);
    localparam logic [VCW-1:0] BY_BEG   = VCW'(BY0);
    localparam logic [VCW-1:0] SUB_MASK = VCW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

    // Pipeline flag bit positions
    localparam int F_HS = 0, F_VS = 1, F_DE = 2, F_WIN = 3, F_BRD = 4, F_FS = 5, NF = 6;

    if (MEM_LAT < 1) begin : g_chk_lat
        $error("MEM_LAT must be at least 1");
    end
    if (BORDER_EN && (WIN_X < 1 || WIN_Y < 1)) begin : g_chk_border_lo
        $error("window border does not fit left/top of active area");
    end
    if (WIN_X + WW + int'(BORDER_EN) > H_ACTIVE || WIN_Y + WH + int'(BORDER_EN) > V_ACTIVE) begin : g_chk_fit
        $error("window does not fit inside active area");
    end
    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_chk_addr
        $error("image does not fit the pixel memory address space");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state_q, state_d;
    logic   run;

    logic [HCW-1:0]    h_cnt_q, h_cnt_d;
    logic [VCW-1:0]    v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q;
    logic [NF-1:0]     flags_q [LAT];
    logic [NF-1:0]     flags_s0;
    logic [7:0]        rgb_q, rgb_d;

    logic h_last, v_last, frame_end, at_origin;
    logic in_x, in_y, in_win, in_bx, in_by, de_s0;
    logic [HCW-1:0]    x_off;
    logic [VCW-1:0]    y_off;
    logic [ADDR_W-1:0] rd_addr;

    assign h_last    = (h_cnt_q == H_LAST);
    assign v_last    = (v_cnt_q == V_LAST);
    assign frame_end = h_last && v_last;
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable && at_origin)  state_d = S_RUN;
            S_RUN:   if (frame_end && !enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run  = (state_q == S_RUN);
        busy = run;
    end

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + VCW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HCW'(1);
        end
    end

    // Position decode for the counter stage
    assign in_x   = (h_cnt_q >= WX_BEG) && (h_cnt_q < WX_END);
    assign in_y   = (v_cnt_q >= WY_BEG) && (v_cnt_q < WY_END);
    assign in_win = run && in_x && in_y;
    assign in_bx  = (h_cnt_q >= BX_BEG) && (h_cnt_q <= WX_END);
    assign in_by  = (v_cnt_q >= BY_BEG) && (v_cnt_q <= WY_END);
    assign de_s0  = run && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

    always_comb begin
        flags_s0        = '0;
        flags_s0[F_HS]  = run && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        flags_s0[F_VS]  = run && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        flags_s0[F_DE]  = de_s0;
        flags_s0[F_WIN] = in_win;
        flags_s0[F_BRD] = BORDER_EN && de_s0 && in_bx && in_by && !(in_x && in_y);
        flags_s0[F_FS]  = run && at_origin;
    end

    // Column comes from the offset shifted down by the scale; rows accumulate IMG_W
    assign x_off    = h_cnt_q - WX_BEG;
    assign y_off    = v_cnt_q - WY_BEG;
    assign rd_addr  = row_base_q + ADDR_W'(x_off >> SCALE_LOG2);
    assign pix_rd   = in_win;
    assign pix_addr = in_win ? rd_addr : addr_q;

    always_comb begin
        row_base_d = row_base_q;
        if (!run || frame_end)
            row_base_d = '0;
        else if (h_last && in_y && ((y_off & SUB_MASK) == SUB_MASK))
            row_base_d = row_base_q + IMG_W_A;
    end

    // Data arrives MEM_LAT cycles after the read, so colour is chosen with flags of that age
    always_comb begin
        rgb_d = BG_GRAY;
        if (!flags_q[MEM_LAT-1][F_DE])      rgb_d = 8'h00;
        else if (flags_q[MEM_LAT-1][F_BRD]) rgb_d = 8'hFF;
        else if (flags_q[MEM_LAT-1][F_WIN]) rgb_d = pix_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            rgb_q      <= '0;
            for (int k = 0; k < LAT; k++) flags_q[k] <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
            if (pix_rd) addr_q <= pix_addr;
            rgb_q      <= rgb_d;
            flags_q[0] <= flags_s0;
            for (int k = 1; k < LAT; k++) flags_q[k] <= flags_q[k-1];
        end
    end

    assign vga_hs      = flags_q[LAT-1][F_HS] ? SYNC_POL : ~SYNC_POL;
    assign vga_vs      = flags_q[LAT-1][F_VS] ? SYNC_POL : ~SYNC_POL;
    assign vga_de      = flags_q[LAT-1][F_DE];
    assign frame_start = flags_q[LAT-1][F_FS];
    assign vga_r       = rgb_q;
    assign vga_g       = rgb_q;
    assign vga_b       = rgb_q;
endmodule

// File: tb/tb_vga_window_scanner.sv
// Randomised bench for vga_window_scanner on a reduced raster, compared every cycle
// against a frame-index reference model with a random-content pixel memory.
module tb_vga_window_scanner;
    localparam int HA = 40, HF = 4, HS = 6, HB = 5;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int WX = 7, WY = 5, IW = 10, IH = 8, SL = 1;
    localparam int AW = 10, ML = 2;
    localparam bit [7:0] BG = 8'h28;
    localparam bit BEN = 1'b1;
    localparam bit SP  = 1'b0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int WW = IW << SL, WH = IH << SL;
    localparam int LAT = ML + 1;

    logic          clk = 1'b0;
    logic          reset_n, enable;
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_data;
    logic          vga_hs, vga_vs, vga_de, frame_start, busy;
    logic [7:0]    vga_r, vga_g, vga_b;

    vga_window_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .WIN_X(WX), .WIN_Y(WY), .IMG_W(IW), .IMG_H(IH), .SCALE_LOG2(SL),
        .ADDR_W(AW), .MEM_LAT(ML), .BG_GRAY(BG), .BORDER_EN(BEN), .SYNC_POL(SP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous pixel memory with ML cycles of read latency
    logic [7:0] mem [1 << AW];
    logic [7:0] mem_pipe [ML];
    always @(posedge clk) begin
        mem_pipe[0] <= mem[pix_addr];
        for (int k = 1; k < ML; k++) mem_pipe[k] <= mem_pipe[k-1];
    end
    assign pix_data = mem_pipe[ML-1];

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference model: frame position as a linear index, history of the last LAT positions
    bit cur_v;
    int cur_idx;
    bit hv [LAT+1];
    int hi [LAT+1];
    int exp_last_addr;
    int cyc, rise_cyc;
    bit fs_pending, busy_prev;

    function automatic bit is_win(input int h, input int v);
        return h >= WX && h < WX + WW && v >= WY && v < WY + WH;
    endfunction

    function automatic int img_addr(input int h, input int v);
        return ((v - WY) / (1 << SL)) * IW + (h - WX) / (1 << SL);
    endfunction

    function automatic logic [7:0] model_rgb(input int idx);
        int h, v;
        h = idx % HT;
        v = idx / HT;
        if (h >= HA || v >= VA) return 8'h00;
        if (BEN && !is_win(h, v) && h >= WX - 1 && h <= WX + WW && v >= WY - 1 && v <= WY + WH)
            return 8'hFF;
        if (is_win(h, v)) return mem[img_addr(h, v)];
        return BG;
    endfunction

    task automatic model_reset();
        cur_v = 0;
        cur_idx = 0;
        for (int k = 0; k <= LAT; k++) begin
            hv[k] = 0;
            hi[k] = 0;
        end
        exp_last_addr = 0;
        fs_pending = 0;
    endtask

    task automatic tick();
        int h, v, oh, ov;
        bit exp_rd, exp_de, exp_hs, exp_vs;
        logic [7:0] er;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            for (int k = LAT; k >= 1; k--) begin
                hv[k] = hv[k-1];
                hi[k] = hi[k-1];
            end
            if (cur_v) begin
                if (cur_idx == FRAME - 1 && !enable) cur_v = 0;
                else cur_idx = (cur_idx + 1) % FRAME;
            end else if (enable) begin
                cur_v = 1;
                cur_idx = 0;
            end
            hv[0] = cur_v;
            hi[0] = cur_idx;
        end
        @(negedge clk);
        cyc++;
        h = cur_idx % HT;
        v = cur_idx / HT;
        check("busy", busy, cur_v);
        exp_rd = cur_v && is_win(h, v);
        check("pix_rd", pix_rd, exp_rd);
        if (exp_rd) exp_last_addr = img_addr(h, v);
        check("pix_addr", pix_addr, exp_last_addr);
        oh = hi[LAT] % HT;
        ov = hi[LAT] / HT;
        exp_hs = hv[LAT] && oh >= HA + HF && oh < HA + HF + HS;
        exp_vs = hv[LAT] && ov >= VA + VF && ov < VA + VF + VS;
        exp_de = hv[LAT] && oh < HA && ov < VA;
        er     = hv[LAT] ? model_rgb(hi[LAT]) : 8'h00;
        check("hs", vga_hs, exp_hs ? SP : !SP);
        check("vs", vga_vs, exp_vs ? SP : !SP);
        check("de", vga_de, exp_de);
        check("rgb", {vga_r, vga_g, vga_b}, {er, er, er});
        check("frame_start", frame_start, hv[LAT] && hi[LAT] == 0);
        // Explicit start-up latency from entering RUN to the first frame_start
        if (busy && !busy_prev) begin
            rise_cyc = cyc;
            fs_pending = 1;
        end
        if (fs_pending && (frame_start || cyc - rise_cyc > LAT + 2)) begin
            check("fs_latency", cyc - rise_cyc, LAT);
            fs_pending = 0;
        end
        busy_prev = busy;
    endtask

    initial begin
        cyc = 0;
        rise_cyc = 0;
        busy_prev = 0;
        model_reset();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        // Continuous run across two full frames
        repeat (2 * FRAME + 10) tick();

        // Enable dropped mid-frame: frame completes, then idle, then restart
        repeat ($urandom_range(100, FRAME - 200)) tick();
        enable = 1'b0;
        repeat (FRAME + $urandom_range(5, 40)) tick();
        enable = 1'b1;
        repeat (FRAME + 20) tick();

        // Enable toggling randomly every cycle; only the frame boundary sample matters
        for (int n = 0; n < 3 * FRAME; n++) begin
            enable = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset in the middle of line 12
        enable = 1'b1;
        for (int n = 0; n < 3 * FRAME && !(cur_v && cur_idx / HT == 12 && cur_idx % HT == 20); n++)
            tick();
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_pix_rd", pix_rd, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_hs", vga_hs, !SP);
        check("rst_vs", vga_vs, !SP);
        check("rst_de", vga_de, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_frame_start", frame_start, 0);
        model_reset();
        repeat ($urandom_range(2, 5)) tick();
        reset_n = 1'b1;
        repeat (FRAME + 20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
